div_ratio_ctrl: RTL and testbench

Runtime controller for the binary clock-divider chain. It produces one divided square wave (`div_out`) with divide ratio 2^(sel+1), sel 0..10, which is f/2 to f/2048 of `clk`, plus a one-cycle `tick` enable on each rising edge. The ratio is reprogrammed through a valid/ready config port. Ratio changes and stops take effect only at period boundaries, so `div_out` never produces a runt pulse. It sits between the system register/config logic and any logic that consumes divided enables. All outputs are registered logic in the `clk` domain; no derived clocks are generated.

---
 rtl/div_ctrl_pkg.sv | 24 ++
 rtl/div_half_counter.sv | 43 ++++
 rtl/div_ratio_ctrl.sv | 113 +++++++++++
 tb/tb_div_ratio_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the binary clock-divider ratio controller.
package div_ctrl_pkg;

    localparam int SEL_W   = 4;
    localparam int MAX_SEL = 10;
    localparam int CNT_W   = MAX_SEL;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Terminal count of the half-period counter: 2^sel - 1.
    function automatic logic [CNT_W-1:0] half_m1(input logic [SEL_W-1:0] sel);
        logic [CNT_W:0] one;
        logic [CNT_W:0] v;
        one = (CNT_W+1)'(1);
        v   = (one << sel) - one;
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/div_half_counter.sv
// Half-period counter producing the divided square wave, its rising-edge
// tick and the period-boundary flag used by the ratio controller.
module div_half_counter
    import div_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] half_m1,
    output logic             div_out,
    output logic             tick,
    output logic             boundary
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap     = run && (cnt == half_m1);
    // The boundary is the wrap that ends a high phase: the next div_out is 0.
    assign boundary = wrap && div_out;

    // Count half periods; toggle the output and flag rising edges on wrap.
    always_ff @(posedge clk) begin
        if (!reset || load) begin
            cnt     <= '0;
            div_out <= 1'b0;
            tick    <= 1'b0;
        end else if (run) begin
            if (wrap) begin
                cnt     <= '0;
                div_out <= ~div_out;
                tick    <= ~div_out;
            end else begin
                cnt     <= cnt + 1'b1;
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/div_ratio_ctrl.sv
// Runtime ratio controller for the binary clock divider. Ratio changes and
// stops are deferred to period boundaries so div_out never emits a runt.
module div_ratio_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int SEL_W   = div_ctrl_pkg::SEL_W,
    parameter int MAX_SEL = div_ctrl_pkg::MAX_SEL,
    parameter int RST_SEL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_out,
    output logic             tick,
    output logic [SEL_W-1:0] active_sel,
    output logic             busy
);

    state_t           state;
    state_t           state_n;
    logic [SEL_W-1:0] pend_sel;
    logic             pend_vld;
    logic             boundary;
    logic             hs;
    logic             legal;
    logic             take_pend;
    logic             apply_cfg;
    logic             apply_pend;

    assign hs    = cfg_valid && cfg_ready;
    assign legal = (cfg_sel <= SEL_W'(MAX_SEL));

    div_half_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state == STOP),
        .run      (state != STOP),
        .half_m1  (half_m1(active_sel)),
        .div_out  (div_out),
        .tick     (tick),
        .boundary (boundary)
    );

    // Next-state and select-update decisions; all changes land on boundaries.
    always_comb begin
        state_n    = state;
        take_pend  = 1'b0;
        apply_cfg  = 1'b0;
        apply_pend = 1'b0;
        case (state)
            STOP: begin
                if (hs && legal) apply_cfg = 1'b1;
                if (en) state_n = RUN;
            end
            RUN: begin
                if (hs && legal) begin
                    take_pend = 1'b1;
                    state_n   = PEND;
                end else if (!en) begin
                    state_n = boundary ? STOP : DRAIN;
                end
            end
            PEND: begin
                if (boundary) begin
                    apply_pend = 1'b1;
                    state_n    = en ? RUN : STOP;
                end
            end
            DRAIN: begin
                if (hs && legal) take_pend = 1'b1;
                if (en) begin
                    state_n = (pend_vld || (hs && legal)) ? PEND : RUN;
                end else if (boundary) begin
                    state_n = STOP;
                    if (hs && legal) apply_cfg = 1'b1;
                    else if (pend_vld) apply_pend = 1'b1;
                end
            end
            default: state_n = STOP;
        endcase
    end

    // Control registers: state, selects, handshake status.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= STOP;
            active_sel <= SEL_W'(RST_SEL);
            pend_vld   <= 1'b0;
            cfg_err    <= 1'b0;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
        end else begin
            state     <= state_n;
            cfg_err   <= hs && !legal;
            busy      <= (state_n != STOP);
            cfg_ready <= (state_n != PEND);
            if (apply_cfg)       active_sel <= cfg_sel;
            else if (apply_pend) active_sel <= pend_sel;
            if (state_n == STOP || state_n == RUN) pend_vld <= 1'b0;
            else if (take_pend)                    pend_vld <= 1'b1;
        end
    end

    // Pending select holds data only; validity is tracked by pend_vld.
    always_ff @(posedge clk) begin
        if (take_pend) pend_sel <= cfg_sel;
    end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
module tb_div_ratio_ctrl;

    localparam int BIG = 32'h3fffffff;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_sel = 4'd0;
    logic       cfg_ready, cfg_err, div_out, tick, busy;
    logic [3:0] active_sel;

    int checks = 0;
    int fails  = 0;

    // Reference model: waveform origin, ratio, pending change, stop point.
    int cyc = 0;
    bit running = 0;
    int org = 0, msel = 0;
    bit pend = 0;
    int pend_hc = 0, pend_at = 0, psel = 0;
    int stop_at = BIG;

    always #5 clk = ~clk;

    div_ratio_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_sel    (cfg_sel),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .div_out    (div_out),
        .tick       (tick),
        .active_sel (active_sel),
        .busy       (busy)
    );

    function automatic bit exp_div(int c);
        if (!running || c >= stop_at || c < org) return 1'b0;
        if (pend && c >= pend_at) return (((c - pend_at) >> psel) % 2) == 1;
        return (((c - org) >> msel) % 2) == 1;
    endfunction

    function automatic bit exp_tick(int c);
        return exp_div(c) && !exp_div(c - 1);
    endfunction

    function automatic bit exp_busy(int c);
        return running && c < stop_at;
    endfunction

    function automatic bit exp_rdy(int c);
        return !(pend && c >= pend_hc && c < pend_at);
    endfunction

    function automatic int exp_sel(int c);
        return (pend && c >= pend_at) ? psel : msel;
    endfunction

    // First period boundary strictly after edge c at the current ratio.
    function automatic int next_b(int c);
        int p;
        p = 1 << (msel + 1);
        return org + ((c - org) / p + 1) * p;
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (pend && cyc >= pend_at) begin
            org  = pend_at;
            msel = psel;
            pend = 0;
        end
        if (running && cyc >= stop_at) begin
            running = 0;
            stop_at = BIG;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        running = 0; pend = 0; stop_at = BIG; msel = 0;
    endtask

    task automatic program_sel(input int s);
        cfg_sel = 4'(s); cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        msel = s;
    endtask

    task automatic go();
        en = 1'b1;
        step();
        org = cyc; running = 1; stop_at = BIG;
    endtask

    task automatic offer(input int s);
        cfg_sel = 4'(s); cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        pend = 1; psel = s; pend_hc = cyc; pend_at = next_b(cyc);
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        step(); step(); step();
        checks++; if (div_out !== 1'b0) begin fails++; $display("FAIL rst_div got=%b exp=0", div_out); end
        checks++; if (tick !== 1'b0) begin fails++; $display("FAIL rst_tick got=%b exp=0", tick); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", cfg_ready); end
        checks++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", cfg_err); end
        checks++; if (active_sel !== 4'd0) begin fails++; $display("FAIL rst_sel got=%0d exp=0", active_sel); end
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++; $display("FAIL rst_release busy=%b ready=%b exp busy=0 ready=1", busy, cfg_ready);
        end
    endtask

    task automatic test_sel0();
        int ticks = 0, bad = 0, first = -1;
        go();
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick === 1'b1) ticks++;
            if (div_out !== exp_div(cyc) || tick !== exp_tick(cyc) || busy !== exp_busy(cyc)) begin
                bad++; if (first < 0) first = cyc - org;
            end
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL sel0_wave bad=%0d first_k=%0d exp bad=0", bad, first); end
        checks++; if (ticks != 10) begin fails++; $display("FAIL sel0_ticks got=%0d exp=10", ticks); end
    endtask

    task automatic test_sel10();
        int ft = -1, st = -1, bad = 0;
        do_reset();
        program_sel(10);
        checks++; if (active_sel !== 4'd10) begin fails++; $display("FAIL sel10_sel got=%0d exp=10", active_sel); end
        go();
        while (st < 0 && cyc - org < 3200) begin
            step();
            if (tick === 1'b1) begin
                if (ft < 0) ft = cyc; else st = cyc;
            end
            if (div_out !== exp_div(cyc) || tick !== exp_tick(cyc)) bad++;
        end
        checks++; if (ft - org != 1024) begin fails++; $display("FAIL sel10_first_tick got=%0d exp=1024", ft - org); end
        checks++; if (st - ft != 2048) begin fails++; $display("FAIL sel10_period got=%0d exp=2048", st - ft); end
        checks++; if (bad != 0) begin fails++; $display("FAIL sel10_wave bad=%0d exp=0", bad); end
    endtask

    task automatic test_ratio_change();
        int bad = 0, first = -1, run_len = 0, min_len = BIG;
        bit last, seen_edge = 0;
        do_reset();
        program_sel(2);
        go();
        for (int i = 0; i < 16 && ((cyc - org) % 8) != 4; i++) step();
        offer(5);
        checks++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL chg_ready_drop got=%b exp=0", cfg_ready); end
        checks++; if (pend_at - org != 8) begin fails++; $display("FAIL chg_boundary_model got=%0d exp=8", pend_at - org); end
        last = div_out;
        while (cyc < pend_at + 64 + 3) begin
            step();
            if (div_out !== last) begin
                if (seen_edge && run_len < min_len) min_len = run_len;
                seen_edge = 1; run_len = 1; last = div_out;
            end else run_len++;
            if (div_out !== exp_div(cyc) || tick !== exp_tick(cyc) || cfg_ready !== exp_rdy(cyc)
                || active_sel !== 4'(exp_sel(cyc))) begin
                bad++; if (first < 0) first = cyc;
            end
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL chg_wave bad=%0d first=%0d exp=0", bad, first); end
        checks++; if (min_len < 4) begin fails++; $display("FAIL chg_min_pulse got=%0d exp>=4", min_len); end
        checks++; if (active_sel !== 4'd5) begin fails++; $display("FAIL chg_sel got=%0d exp=5", active_sel); end
    endtask

    task automatic test_random_ratio();
        for (int it = 0; it < 6; it++) begin
            int s0, s1, w, bad = 0, first = -1;
            s0 = int'($urandom_range(0, 4));
            s1 = int'($urandom_range(0, 5));
            do_reset();
            program_sel(s0);
            go();
            w = int'($urandom_range(1, 3 * (2 << s0)));
            for (int i = 0; i < w; i++) step();
            offer(s1);
            while (cyc < pend_at + 2 * (2 << s1) + 3) begin
                step();
                if (div_out !== exp_div(cyc) || tick !== exp_tick(cyc) || cfg_ready !== exp_rdy(cyc)
                    || active_sel !== 4'(exp_sel(cyc)) || busy !== exp_busy(cyc)) begin
                    bad++; if (first < 0) first = cyc;
                end
            end
            checks++;
            if (bad != 0) begin
                fails++; $display("FAIL rnd_chg s0=%0d s1=%0d w=%0d bad=%0d first=%0d exp=0", s0, s1, w, bad, first);
            end
        end
    endtask

    task automatic test_illegal();
        int bad = 0, s;
        do_reset();
        program_sel(3);
        go();
        for (int i = 0; i < int'($urandom_range(2, 20)); i++) step();
        s = int'($urandom_range(11, 15));
        cfg_sel = 4'(s); cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL ill_err sel=%0d got=%b exp=1", s, cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL ill_ready got=%b exp=1", cfg_ready); end
        step();
        checks++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL ill_err_clear got=%b exp=0", cfg_err); end
        for (int i = 0; i < 40; i++) begin
            step();
            if (div_out !== exp_div(cyc) || tick !== exp_tick(cyc) || active_sel !== 4'd3 || cfg_err !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL ill_wave bad=%0d exp=0", bad); end
    endtask

    task automatic test_en_drop();
        int bad = 0, kd, n;
        do_reset();
        program_sel(3);
        go();
        n = int'($urandom_range(20, 29));
        for (int i = 0; i < n; i++) step();
        en = 1'b0;
        kd = cyc + 1;
        stop_at = org + ((kd - org + 15) / 16) * 16;
        n = stop_at + 10;
        while (cyc < n) begin
            step();
            if (div_out !== exp_div(cyc) || tick !== exp_tick(cyc) || busy !== exp_busy(cyc)) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL drop_wave bad=%0d exp=0", bad); end
        checks++; if (busy !== 1'b0 || div_out !== 1'b0) begin
            fails++; $display("FAIL drop_stopped busy=%b div=%b exp 0/0", busy, div_out);
        end
        go();
        bad = 0;
        for (int i = 0; i < 16 && ((cyc - org) % 16) != 2; i++) step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (div_out !== exp_div(cyc) || busy !== 1'b1) bad++;
        end
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (div_out !== exp_div(cyc) || tick !== exp_tick(cyc) || busy !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL reraise_wave bad=%0d exp=0", bad); end
    endtask

    task automatic test_reset_pend();
        int bad = 0;
        do_reset();
        program_sel(2);
        go();
        for (int i = 0; i < 16 && ((cyc - org) % 8) != 4; i++) step();
        offer(5);
        checks++; if (div_out !== 1'b1 || cfg_ready !== 1'b0) begin
            fails++; $display("FAIL rp_setup div=%b ready=%b exp 1/0", div_out, cfg_ready);
        end
        reset = 1'b0;
        step();
        running = 0; pend = 0; msel = 0;
        checks++; if (div_out !== 1'b0) begin fails++; $display("FAIL rp_div got=%b exp=0", div_out); end
        checks++; if (active_sel !== 4'd0) begin fails++; $display("FAIL rp_sel got=%0d exp=0", active_sel); end
        checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rp_ready got=%b exp=1", cfg_ready); end
        checks++; if (busy !== 1'b0 || tick !== 1'b0) begin
            fails++; $display("FAIL rp_busy_tick busy=%b tick=%b exp 0/0", busy, tick);
        end
        reset = 1'b1;
        step();
        org = cyc; running = 1; stop_at = BIG;
        for (int i = 0; i < 24; i++) begin
            step();
            if (div_out !== exp_div(cyc) || tick !== exp_tick(cyc) || active_sel !== 4'd0) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL rp_discard bad=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_sel0();
        test_sel10();
        test_ratio_change();
        test_random_ratio();
        test_illegal();
        test_en_drop();
        test_reset_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
